// File: rtl/vga_scanout_if.sv
// vga_scanout_if: framebuffer read port between the VGA scanout engine and the
// framebuffer memory.
//   fb_rd_en  - read strobe, one per visible pixel (scanout -> memory)
//   fb_addr   - linear pixel address y*H_ACTIVE+x (scanout -> memory)
//   fb_rdata  - {R,G,B} read data, valid the cycle after fb_rd_en (memory -> scanout)
interface vga_scanout_if #(
  parameter int ADDR_W = 19
);
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_rdata;

  modport master (output fb_rd_en, output fb_addr, input fb_rdata);
  modport slave  (input fb_rd_en, input fb_addr, output fb_rdata);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: free-running VGA timing generator and framebuffer scanout.
// Walks the full raster, issues one framebuffer read per visible pixel in raster
// order and drives registered RGB, syncs and data-enable, mutually aligned with a
// fixed 3-cycle counter-to-pin latency.
// Ports:
//   clk, reset        - pixel clock, synchronous active-high reset
//   fb                - framebuffer read port (vga_scanout_if master)
//   vga_r/g/b         - pixel colour, zero outside the visible area
//   hsync, vsync      - active-low syncs
//   de                - data enable, high on visible pixels
//   frame_start       - one-cycle pulse with pixel (0,0) at the pins
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_scanout_if.master        fb,
  output logic [7:0]           vga_r,
  output logic [7:0]           vga_g,
  output logic [7:0]           vga_b,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_ONE  = VW'(1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  logic [HW-1:0]     hcount;
  logic [VW-1:0]     vcount;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] addr_base;
  logic              active, origin, hs_n, vs_n;

  // stage 1 / stage 2 sideband, delayed to stay aligned with fb_rdata
  logic s1_de, s1_hs, s1_vs, s1_fs;
  logic s2_de, s2_hs, s2_vs, s2_fs;

  // stage 0: raster position
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + V_ONE;
    end else begin
      hcount <= hcount + H_ONE;
    end
  end

  assign active = (hcount < H_ACT) && (vcount < V_ACT);
  assign origin = (hcount == '0) && (vcount == '0);
  assign hs_n   = !((hcount >= H_SS) && (hcount < H_SE));
  assign vs_n   = !((vcount >= V_SS) && (vcount < V_SE));
  // Restart the incremental address at the top of every frame so a glitch
  // can never leave the scan permanently offset.
  assign addr_base = origin ? '0 : addr_cnt;

  // stage 1: read request
  always_ff @(posedge clk) begin
    if (reset) begin
      fb.fb_rd_en <= 1'b0;
      fb.fb_addr  <= '0;
      addr_cnt    <= '0;
      s1_de       <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_fs       <= 1'b0;
    end else begin
      fb.fb_rd_en <= active;
      if (active) begin
        fb.fb_addr <= addr_base;
        addr_cnt   <= addr_base + A_ONE;
      end
      s1_de <= active;
      s1_hs <= hs_n;
      s1_vs <= vs_n;
      s1_fs <= origin;
    end
  end

  // stage 2: memory access cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_de <= 1'b0;
      s2_hs <= 1'b1;
      s2_vs <= 1'b1;
      s2_fs <= 1'b0;
    end else begin
      s2_de <= s1_de;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
      s2_fs <= s1_fs;
    end
  end

  // stage 3: pins
  always_ff @(posedge clk) begin
    if (reset) begin
      {vga_r, vga_g, vga_b} <= '0;
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= s2_de ? fb.fb_rdata : 24'h0;
      de          <= s2_de;
      hsync       <= s2_hs;
      vsync       <= s2_vs;
      frame_start <= s2_fs;
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout with full horizontal timing
// and a shortened vertical raster so several frames fit in a short run.
module tb_vga_scanout;
  localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int AW = 19;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_scanout_if #(.ADDR_W(AW)) fb();
  logic [7:0] vga_r, vga_g, vga_b;
  logic hsync, vsync, de, frame_start;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .fb(fb),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
  );

  // memory model: keyed address pattern on reads, garbage otherwise
  logic [23:0] key;
  always @(posedge clk) begin
    if (fb.fb_rd_en)
      fb.fb_rdata <= {5'b0, fb.fb_addr} ^ key;
    else
      fb.fb_rdata <= ($urandom_range(0, 1) == 1) ? 24'hffffff : 24'($urandom);
  end

  typedef struct packed {
    logic          rd_en;
    logic [AW-1:0] addr;
    logic          chk_addr;
    logic          de;
    logic          hs;
    logic          vs;
    logic          fs;
    logic [23:0]   rgb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;
  bit   stats_on = 0;
  int   p = 0;

  // reference model: p = clock edges since reset was last sampled high
  always @(posedge clk) begin
    exp_t e;
    int k, h, v;
    if (reset) begin
      p = 0;
      started = 1;
    end else if (started) begin
      p++;
    end
    if (started) begin
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.chk_addr = (p == 0);
      if (p >= 1) begin
        k = (p - 1) % FRAME;
        h = k % HT;
        v = k / HT;
        e.rd_en = (h < HA) && (v < VA);
        e.chk_addr = e.rd_en;
        e.addr = AW'(v * HA + h);
      end
      if (p >= 3) begin
        k = (p - 3) % FRAME;
        h = k % HT;
        v = k / HT;
        e.de  = (h < HA) && (v < VA);
        e.hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
        e.vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
        e.fs  = (h == 0) && (v == 0);
        e.rgb = e.de ? (24'(v * HA + h) ^ key) : 24'h0;
      end
      q.push_back(e);
    end
  end

  // monitor: per-cycle scoreboard plus aggregate timing statistics
  int cyc = 0, de_fall = -1000000, derun = 0, hrun = 0, vrun = 0;
  int rd_cnt = 0, fs_cyc = 0, nfs = 0;
  bit have_fs = 0, have_last = 0;
  bit de_prev = 0, hs_prev = 1, vs_prev = 1;
  logic [AW-1:0] last_addr = '0;

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({fb.fb_rd_en, de, hsync, vsync, frame_start, vga_r, vga_g, vga_b} !==
          {e.rd_en, e.de, e.hs, e.vs, e.fs, e.rgb}) begin
        errors++;
        $display("FAIL pins t=%0t got rd_en=%b de=%b hs=%b vs=%b fs=%b rgb=%h exp rd_en=%b de=%b hs=%b vs=%b fs=%b rgb=%h",
                 $time, fb.fb_rd_en, de, hsync, vsync, frame_start, {vga_r, vga_g, vga_b},
                 e.rd_en, e.de, e.hs, e.vs, e.fs, e.rgb);
      end
      if (e.chk_addr) begin
        checks++;
        if (fb.fb_addr !== e.addr) begin
          errors++;
          $display("FAIL fb_addr t=%0t got %0d exp %0d", $time, fb.fb_addr, e.addr);
        end
      end
    end

    if (stats_on) begin
      cyc++;
      if (de) derun++;
      if (de_prev && !de) begin
        checks++;
        if (derun != HA) begin
          errors++;
          $display("FAIL de_run got %0d exp %0d", derun, HA);
        end
        derun = 0;
        de_fall = cyc;
      end
      if (!hsync) hrun++;
      if (hs_prev && !hsync && (cyc - de_fall) < HT) begin
        checks++;
        if (cyc - de_fall != HFP) begin
          errors++;
          $display("FAIL hsync_offset got %0d exp %0d", cyc - de_fall, HFP);
        end
      end
      if (!hs_prev && hsync) begin
        checks++;
        if (hrun != HS) begin
          errors++;
          $display("FAIL hsync_width got %0d exp %0d", hrun, HS);
        end
        hrun = 0;
      end
      if (!vsync) vrun++;
      if (vs_prev && !vsync) begin
        checks++;
        if (cyc - de_fall != (VFP + 1) * HT - HA) begin
          errors++;
          $display("FAIL vsync_offset got %0d exp %0d", cyc - de_fall, (VFP + 1) * HT - HA);
        end
      end
      if (!vs_prev && vsync) begin
        checks++;
        if (vrun != VS * HT) begin
          errors++;
          $display("FAIL vsync_width got %0d exp %0d", vrun, VS * HT);
        end
        vrun = 0;
      end
      if (fb.fb_rd_en) begin
        rd_cnt++;
        if (fb.fb_addr == '0 && have_last) begin
          checks++;
          if (last_addr != AW'(HA * VA - 1)) begin
            errors++;
            $display("FAIL last_addr got %0d exp %0d", last_addr, HA * VA - 1);
          end
        end
        last_addr = fb.fb_addr;
        have_last = 1;
      end
      if (frame_start) begin
        if (have_fs) begin
          checks++;
          if (cyc - fs_cyc != FRAME) begin
            errors++;
            $display("FAIL frame_period got %0d exp %0d", cyc - fs_cyc, FRAME);
          end
          checks++;
          if (rd_cnt != HA * VA) begin
            errors++;
            $display("FAIL reads_per_frame got %0d exp %0d", rd_cnt, HA * VA);
          end
        end
        nfs++;
        fs_cyc = cyc;
        rd_cnt = 0;
        have_fs = 1;
      end
      de_prev = de;
      hs_prev = hsync;
      vs_prev = vsync;
    end
  end

  initial begin
    key = 24'($urandom);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    // single-cycle reset in the middle of a visible line
    repeat (HT * 5 + 300) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(10, FRAME / 2)) @(posedge clk);
      #1 reset = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 reset = 1'b0;
    end
    repeat ($urandom_range(1, 100)) @(posedge clk);
    #1 reset = 1'b1;
    repeat ($urandom_range(3, 8)) @(posedge clk);
    #1 reset = 1'b0;
    stats_on = 1;
    repeat (2 * FRAME + 100) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (nfs < 3) begin
      errors++;
      $display("FAIL frame_count got %0d exp at least %0d", nfs, 3);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
